// File: rtl/bram_stream_pkg.sv
// Shared types and constants for the block-RAM stream buffer controller.
package bram_stream_pkg;

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_e;

  // Output FIFO depth; two entries cover the one-cycle RAM read latency.
  localparam int unsigned FIFO_DEPTH = 2;

endpackage

// File: rtl/stream_fifo2.sv
// Two-entry registered FIFO; entry 0 is always the head.
module stream_fifo2
  import bram_stream_pkg::*;
#(
  parameter int unsigned WIDTH = 9
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [1:0]       count_o,
  output logic [WIDTH-1:0] head_o
);

  logic [WIDTH-1:0] e0_q, e0_d, e1_q, e1_d;
  logic [1:0]       cnt_q, cnt_d;

  assign count_o = cnt_q;
  assign head_o  = e0_q;

  // Next entries and occupancy for push, pop, or both in the same cycle.
  always_comb begin
    e0_d  = e0_q;
    e1_d  = e1_q;
    cnt_d = cnt_q;
    if (push_i && pop_i) begin
      if (cnt_q == 2'(FIFO_DEPTH)) begin
        e0_d = e1_q;
        e1_d = push_data_i;
      end else begin
        e0_d = push_data_i;
      end
    end else if (push_i) begin
      if (cnt_q == 2'd0) begin
        e0_d  = push_data_i;
        cnt_d = 2'd1;
      end else if (cnt_q == 2'd1) begin
        e1_d  = push_data_i;
        cnt_d = 2'd2;
      end
    end else if (pop_i) begin
      e0_d = e1_q;
      if (cnt_q != 2'd0) cnt_d = cnt_q - 2'd1;
    end
  end

  // Storage and count registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      e0_q  <= '0;
      e1_q  <= '0;
      cnt_q <= '0;
    end else begin
      e0_q  <= e0_d;
      e1_q  <= e1_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/bram_stream_ctrl.sv
// Captures one AXI-Stream frame into a single-port RAM, then replays it in
// address order through a two-entry output FIFO with read credit control.
module bram_stream_ctrl
  import bram_stream_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 256
) (
  input  logic                  i_clk,
  input  logic                  rstn,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  o_ce,
  output logic                  o_write,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic [DATA_WIDTH-1:0] o_wdata,
  input  logic [DATA_WIDTH-1:0] i_rdata,
  output logic                  o_busy,
  output logic                  o_overflow
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  state_e                state_q, state_d;
  logic                  run_q;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d, len_q, len_d;
  logic                  ovf_q, ovf_d;
  logic                  infl_q, infl_d, infl_last_q, infl_last_d;
  logic                  fifo_pop;
  logic [1:0]            fifo_count;
  logic [DATA_WIDTH:0]   fifo_head;
  logic [2:0]            occupancy;
  logic                  read_ok;

  assign m_axis_tvalid = (fifo_count != 2'd0);
  assign m_axis_tdata  = fifo_head[DATA_WIDTH-1:0];
  assign m_axis_tlast  = fifo_head[DATA_WIDTH];
  assign fifo_pop      = m_axis_tvalid && m_axis_tready;
  assign o_busy        = (state_q == DRAIN);
  assign o_overflow    = ovf_q;

  // A pop this cycle frees a slot, so it is credited before deciding to read.
  assign occupancy = {1'b0, fifo_count} + {2'b00, infl_q};
  assign read_ok   = occupancy < (3'(FIFO_DEPTH) + {2'b00, fifo_pop});

  stream_fifo2 #(
    .WIDTH(DATA_WIDTH + 1)
  ) u_fifo (
    .clk_i      (i_clk),
    .rst_ni     (rstn),
    .push_i     (infl_q),
    .push_data_i({infl_last_q, i_rdata}),
    .pop_i      (fifo_pop),
    .count_o    (fifo_count),
    .head_o     (fifo_head)
  );

  // FSM next state, pointer updates and RAM port muxing.
  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    len_d         = len_q;
    ovf_d         = ovf_q;
    infl_d        = 1'b0;
    infl_last_d   = 1'b0;
    s_axis_tready = 1'b0;
    o_ce          = 1'b0;
    o_write       = 1'b0;
    o_addr        = '0;
    o_wdata       = '0;
    unique case (state_q)
      FILL: begin
        s_axis_tready = run_q;
        if (s_axis_tvalid && run_q) begin
          o_ce     = 1'b1;
          o_write  = 1'b1;
          o_addr   = wr_ptr_q;
          o_wdata  = s_axis_tdata;
          wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
          if (wr_ptr_q == '0) ovf_d = 1'b0;
          if (s_axis_tlast || (wr_ptr_q == LAST_ADDR)) begin
            len_d   = {1'b0, wr_ptr_q} + (ADDR_WIDTH + 1)'(1);
            state_d = DRAIN;
            if (!s_axis_tlast) ovf_d = 1'b1;
          end
        end
      end
      DRAIN: begin
        if ((rd_ptr_q < len_q) && read_ok) begin
          o_ce        = 1'b1;
          o_addr      = rd_ptr_q[ADDR_WIDTH-1:0];
          rd_ptr_d    = rd_ptr_q + (ADDR_WIDTH + 1)'(1);
          infl_d      = 1'b1;
          infl_last_d = (rd_ptr_q == len_q - (ADDR_WIDTH + 1)'(1));
        end
        if (fifo_pop && m_axis_tlast) begin
          state_d  = FILL;
          wr_ptr_d = '0;
          rd_ptr_d = '0;
        end
      end
      default: state_d = FILL;
    endcase
  end

  // State, pointer and read-in-flight registers.
  always_ff @(posedge i_clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= FILL;
      run_q       <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      len_q       <= '0;
      ovf_q       <= 1'b0;
      infl_q      <= 1'b0;
      infl_last_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      run_q       <= 1'b1;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      len_q       <= len_d;
      ovf_q       <= ovf_d;
      infl_q      <= infl_d;
      infl_last_q <= infl_last_d;
    end
  end

endmodule

// File: tb/tb_bram_stream_ctrl.sv
// Directed bench for bram_stream_ctrl with a behavioural single-port RAM.
module tb_bram_stream_ctrl;

  localparam int AW    = 8;
  localparam int DW    = 8;
  localparam int DEPTH = 256;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [DW-1:0] s_tdata = '0;
  logic          s_tvalid = 1'b0;
  logic          s_tready;
  logic          s_tlast = 1'b0;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tready = 1'b0;
  logic          m_tlast;
  logic          o_ce, o_write;
  logic [AW-1:0] o_addr;
  logic [DW-1:0] o_wdata;
  logic [DW-1:0] i_rdata = '0;
  logic          o_busy, o_overflow;

  always #5 clk = ~clk;

  bram_stream_ctrl #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .DEPTH     (DEPTH)
  ) dut (
    .i_clk        (clk),
    .rstn         (rstn),
    .s_axis_tdata (s_tdata),
    .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready),
    .s_axis_tlast (s_tlast),
    .m_axis_tdata (m_tdata),
    .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready),
    .m_axis_tlast (m_tlast),
    .o_ce         (o_ce),
    .o_write      (o_write),
    .o_addr       (o_addr),
    .o_wdata      (o_wdata),
    .i_rdata      (i_rdata),
    .o_busy       (o_busy),
    .o_overflow   (o_overflow)
  );

  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (o_ce) begin
      if (o_write) mem[o_addr] <= o_wdata;
      else         i_rdata     <= mem[o_addr];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [7:0]  tx_q[$];
  logic [7:0]  got_d[$];
  logic        got_l[$];
  int          last_in_edge, first_edge, end_edge;
  int          stab_err, max_out, coll_err, wr_err;
  bit          drain_to;
  logic [15:0] pat = 16'b1001_0110_1001_1100;
  int          pidx = 0;

  task automatic push_frame(input int addr0, input bit last_on_end, input bit hold);
    for (int i = 0; i < tx_q.size(); i++) begin
      int k;
      k = 0;
      s_tdata  = tx_q[i];
      s_tlast  = last_on_end && (i == tx_q.size() - 1);
      s_tvalid = 1'b1;
      #1;
      while (!s_tready && k < 400) begin
        @(posedge clk); #1;
        k++;
      end
      if (k >= 400) begin
        wr_err++;
        break;
      end
      if (!(o_ce === 1'b1 && o_write === 1'b1 && o_addr === 8'(addr0 + i) && o_wdata === tx_q[i]))
        wr_err++;
      last_in_edge = cyc + 1;
      @(posedge clk); #1;
    end
    s_tvalid = hold;
    s_tlast  = 1'b0;
  endtask

  task automatic drain(input int stop_after, input bit use_pat, input int maxcyc);
    int outst;
    bit prev_stall, done;
    logic [7:0] prev_d;
    logic prev_l;
    outst = 0; prev_stall = 0; done = 0; prev_d = '0; prev_l = 1'b0;
    got_d.delete(); got_l.delete();
    first_edge = -1; end_edge = -1; stab_err = 0; max_out = 0; coll_err = 0; drain_to = 0;
    for (int c = 0; c < maxcyc && !done; c++) begin
      @(negedge clk);
      if (use_pat) begin
        m_tready = pat[pidx % 16];
        pidx++;
      end else begin
        m_tready = 1'b1;
      end
      #1;
      if (prev_stall && (m_tvalid !== 1'b1 || m_tdata !== prev_d || m_tlast !== prev_l)) stab_err++;
      if (o_ce && !o_write) outst++;
      if (s_tready && o_ce && !o_write) coll_err++;
      if (o_busy && s_tready) coll_err++;
      if (o_busy && o_ce && o_write) coll_err++;
      if (m_tvalid && first_edge < 0) first_edge = cyc;
      prev_stall = m_tvalid && !m_tready;
      prev_d = m_tdata;
      prev_l = m_tlast;
      if (m_tvalid && m_tready) begin
        got_d.push_back(m_tdata);
        got_l.push_back(m_tlast);
        outst--;
        if (m_tlast) begin
          end_edge = cyc + 1;
          done = 1;
        end
        if (got_d.size() == stop_after) done = 1;
      end
      if (outst > max_out) max_out = outst;
    end
    if (!done) drain_to = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; s_tvalid = 1'b1; s_tdata = 8'h5A; m_tready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({s_tready, m_tvalid, m_tlast, o_ce, o_write, o_busy, o_overflow, m_tdata, o_addr, o_wdata} !== 31'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %0h expected 0",
               {s_tready, m_tvalid, m_tlast, o_ce, o_write, o_busy, o_overflow, m_tdata, o_addr, o_wdata});
    end
    s_tvalid = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    #1;
    n_checks++;
    if (s_tready !== 1'b0) begin n_fail++; $display("FAIL ready_before_edge: got %0b expected 0", s_tready); end
    @(posedge clk); #1;
    n_checks++;
    if (s_tready !== 1'b1) begin n_fail++; $display("FAIL ready_after_edge: got %0b expected 1", s_tready); end
  endtask

  task automatic test_basic();
    wr_err = 0;
    tx_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    push_frame(0, 1'b1, 1'b0);
    drain(0, 1'b0, 50);
    n_checks++;
    if (wr_err !== 0) begin n_fail++; $display("FAIL basic_write_port: got %0d errors expected 0", wr_err); end
    n_checks++;
    if (got_d.size() !== 4 || drain_to) begin n_fail++; $display("FAIL basic_count: got %0d expected 4", got_d.size()); end
    n_checks++;
    if ({got_d[0], got_d[1], got_d[2], got_d[3]} !== 32'h11223344) begin
      n_fail++; $display("FAIL basic_data: got %0h expected 11223344", {got_d[0], got_d[1], got_d[2], got_d[3]});
    end
    n_checks++;
    if ({got_l[0], got_l[1], got_l[2], got_l[3]} !== 4'b0001) begin
      n_fail++; $display("FAIL basic_last: got %0b expected 0001", {got_l[0], got_l[1], got_l[2], got_l[3]});
    end
    n_checks++;
    if (first_edge - last_in_edge !== 2) begin
      n_fail++; $display("FAIL basic_latency: got %0d expected 2", first_edge - last_in_edge);
    end
    n_checks++;
    if (end_edge - last_in_edge !== 6) begin
      n_fail++; $display("FAIL basic_drain_cycles: got %0d expected 6", end_edge - last_in_edge);
    end
    n_checks++;
    if (o_overflow !== 1'b0) begin n_fail++; $display("FAIL basic_overflow: got %0b expected 0", o_overflow); end
  endtask

  task automatic test_single();
    tx_q = '{8'hA5};
    push_frame(0, 1'b1, 1'b0);
    drain(0, 1'b0, 50);
    n_checks++;
    if (got_d.size() !== 1 || got_d[0] !== 8'hA5 || got_l[0] !== 1'b1) begin
      n_fail++; $display("FAIL single_beat: got n=%0d d=%0h l=%0b expected n=1 d=a5 l=1", got_d.size(), got_d[0], got_l[0]);
    end
    n_checks++;
    if (end_edge - last_in_edge !== 3) begin
      n_fail++; $display("FAIL single_drain_cycles: got %0d expected 3", end_edge - last_in_edge);
    end
    n_checks++;
    if ({o_busy, s_tready} !== 2'b01) begin
      n_fail++; $display("FAIL single_back_to_fill: got busy,ready=%0b expected 01", {o_busy, s_tready});
    end
  endtask

  task automatic test_overflow();
    int derr, lerr;
    derr = 0; lerr = 0; wr_err = 0;
    tx_q.delete();
    for (int i = 0; i < 256; i++) tx_q.push_back(8'((i * 7 + 3) & 255));
    push_frame(0, 1'b0, 1'b0);
    n_checks++;
    if ({o_overflow, o_busy, s_tready} !== 3'b110) begin
      n_fail++; $display("FAIL ovf_forced_end: got ovf,busy,ready=%0b expected 110", {o_overflow, o_busy, s_tready});
    end
    drain(0, 1'b0, 700);
    n_checks++;
    if (got_d.size() !== 256 || drain_to) begin n_fail++; $display("FAIL ovf_count: got %0d expected 256", got_d.size()); end
    for (int i = 0; i < got_d.size(); i++) begin
      if (got_d[i] !== 8'((i * 7 + 3) & 255)) derr++;
      if (got_l[i] !== (i == 255)) lerr++;
    end
    n_checks++;
    if (derr !== 0 || lerr !== 0) begin
      n_fail++; $display("FAIL ovf_contents: got %0d data and %0d last errors expected 0", derr, lerr);
    end
    n_checks++;
    if (o_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %0b expected 1", o_overflow); end
    tx_q = '{8'hF0};
    push_frame(0, 1'b0, 1'b0);
    n_checks++;
    if (o_overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %0b expected 0", o_overflow); end
    tx_q = '{8'hF1, 8'hF2, 8'hF3};
    push_frame(1, 1'b0, 1'b0);
    n_checks++;
    if (o_busy !== 1'b0) begin n_fail++; $display("FAIL ovf_next_frame_open: got busy=%0b expected 0", o_busy); end
    tx_q = '{8'hF4};
    push_frame(4, 1'b1, 1'b0);
    drain(0, 1'b0, 50);
    n_checks++;
    if (wr_err !== 0) begin n_fail++; $display("FAIL ovf_write_port: got %0d errors expected 0", wr_err); end
    n_checks++;
    if (got_d.size() !== 5 || {got_d[0], got_d[1], got_d[2], got_d[3], got_d[4]} !== 40'hF0F1F2F3F4 ||
        {got_l[0], got_l[1], got_l[2], got_l[3], got_l[4]} !== 5'b00001) begin
      n_fail++; $display("FAIL ovf_second_frame: got n=%0d d=%0h expected n=5 d=f0f1f2f3f4",
                         got_d.size(), {got_d[0], got_d[1], got_d[2], got_d[3], got_d[4]});
    end
  endtask

  task automatic test_backpressure();
    int derr;
    derr = 0;
    tx_q = '{8'h81, 8'h82, 8'h83, 8'h84, 8'h85, 8'h86, 8'h87, 8'h88};
    push_frame(0, 1'b1, 1'b0);
    drain(0, 1'b1, 200);
    n_checks++;
    if (got_d.size() !== 8 || drain_to) begin n_fail++; $display("FAIL bp_count: got %0d expected 8", got_d.size()); end
    for (int i = 0; i < got_d.size(); i++) begin
      if (got_d[i] !== 8'(8'h81 + i)) derr++;
      if (got_l[i] !== (i == 7)) derr++;
    end
    n_checks++;
    if (derr !== 0) begin n_fail++; $display("FAIL bp_order: got %0d errors expected 0", derr); end
    n_checks++;
    if (stab_err !== 0) begin n_fail++; $display("FAIL bp_stall_stable: got %0d changes expected 0", stab_err); end
    n_checks++;
    if (max_out > 2) begin n_fail++; $display("FAIL bp_outstanding: got %0d expected at most 2", max_out); end
    m_tready = 1'b1;
  endtask

  task automatic test_reset_mid_drain();
    tx_q = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66};
    push_frame(0, 1'b1, 1'b0);
    drain(3, 1'b0, 50);
    n_checks++;
    if (got_d.size() !== 3 || {got_d[0], got_d[1], got_d[2]} !== 24'h616263) begin
      n_fail++; $display("FAIL rst_partial: got %0h expected 616263", {got_d[0], got_d[1], got_d[2]});
    end
    #2;
    rstn = 1'b0;
    #1;
    n_checks++;
    if ({s_tready, m_tvalid, m_tlast, o_ce, o_write, o_busy, o_overflow, m_tdata, o_addr, o_wdata} !== 31'd0) begin
      n_fail++;
      $display("FAIL rst_async_outputs: got %0h expected 0",
               {s_tready, m_tvalid, m_tlast, o_ce, o_write, o_busy, o_overflow, m_tdata, o_addr, o_wdata});
    end
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk); #1;
    tx_q = '{8'h01, 8'h02};
    push_frame(0, 1'b1, 1'b0);
    drain(0, 1'b0, 50);
    n_checks++;
    if (got_d.size() !== 2 || {got_d[0], got_d[1]} !== 16'h0102 || {got_l[0], got_l[1]} !== 2'b01) begin
      n_fail++; $display("FAIL rst_next_frame: got n=%0d d=%0h expected n=2 d=0102", got_d.size(), {got_d[0], got_d[1]});
    end
  endtask

  task automatic test_back_to_back();
    tx_q = '{8'hB1, 8'hB2, 8'hB3};
    push_frame(0, 1'b1, 1'b1);
    s_tdata = 8'hC1;
    drain(0, 1'b0, 50);
    n_checks++;
    if (coll_err !== 0) begin n_fail++; $display("FAIL b2b_no_accept_in_drain: got %0d events expected 0", coll_err); end
    n_checks++;
    if (got_d.size() !== 3 || {got_d[0], got_d[1], got_d[2]} !== 24'hB1B2B3) begin
      n_fail++; $display("FAIL b2b_frame_a: got %0h expected b1b2b3", {got_d[0], got_d[1], got_d[2]});
    end
    n_checks++;
    if ({s_tready, o_ce, o_write, o_addr, o_wdata} !== {3'b111, 8'h00, 8'hC1}) begin
      n_fail++; $display("FAIL b2b_turnaround: got %0h expected %0h", {s_tready, o_ce, o_write, o_addr, o_wdata},
                         {3'b111, 8'h00, 8'hC1});
    end
    tx_q = '{8'hC1, 8'hC2};
    push_frame(0, 1'b1, 1'b0);
    drain(0, 1'b0, 50);
    n_checks++;
    if (coll_err !== 0 || got_d.size() !== 2 || {got_d[0], got_d[1]} !== 16'hC1C2) begin
      n_fail++; $display("FAIL b2b_frame_b: got n=%0d d=%0h coll=%0d expected n=2 d=c1c2 coll=0",
                         got_d.size(), {got_d[0], got_d[1]}, coll_err);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_single();
    test_overflow();
    test_backpressure();
    test_reset_mid_drain();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
